// File: rtl/text_entry_buffer.sv
// Keystroke assembler for the text overlay: edits a working buffer and commits it to the
// stringmaker bus on the frame boundary after Enter. The committed bus is named string_bus
// because "string" is a reserved word in SystemVerilog.
module text_entry_buffer #(
    parameter int STRING_LENGTH = 9,
    parameter int ARRAY_LEN     = 8 * STRING_LENGTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           char_in,
    input  logic                 char_valid,
    input  logic                 frame_start,
    output logic [ARRAY_LEN-1:0] string_bus,
    output logic [5:0]           numchar,
    output logic                 ready,
    output logic [ARRAY_LEN-1:0] edit_string,
    output logic [5:0]           edit_count,
    output logic                 pending,
    output logic                 dropped
);

    typedef enum logic [1:0] {
        ST_EDIT    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    localparam logic [ARRAY_LEN-1:0] BLANK = {STRING_LENGTH{8'h20}};
    localparam logic [5:0]           FULL  = 6'(STRING_LENGTH);

    state_t               state_r, next_state_s;
    logic [ARRAY_LEN-1:0] edit_buf_r, edit_buf_next_s;
    logic [5:0]           edit_count_r, edit_count_next_s;
    logic [ARRAY_LEN-1:0] string_r;
    logic [5:0]           numchar_r;
    logic                 ready_r, pending_r, dropped_r;
    logic                 dropped_next_s, commit_s;
    logic                 is_upper_s, is_lower_s, is_space_s, is_print_s;
    logic [7:0]           key_char_s;

    // Overwrite one slot of the buffer; char 0 occupies the top byte.
    function automatic logic [ARRAY_LEN-1:0] put_char(input logic [ARRAY_LEN-1:0] buf_in,
                                                      input logic [5:0]           slot,
                                                      input logic [7:0]           ch);
        logic [ARRAY_LEN-1:0] res;
        res = buf_in;
        for (int i = 0; i < STRING_LENGTH; i++) begin
            if (slot == 6'(i)) begin
                res[ARRAY_LEN-1-8*i -: 8] = ch;
            end else begin
                res[ARRAY_LEN-1-8*i -: 8] = buf_in[ARRAY_LEN-1-8*i -: 8];
            end
        end
        return res;
    endfunction

    assign is_upper_s = (char_in >= 8'h41) && (char_in <= 8'h5A);
    assign is_lower_s = (char_in >= 8'h61) && (char_in <= 8'h7A);
    assign is_space_s = (char_in == 8'h20);
    assign is_print_s = is_upper_s || is_lower_s || is_space_s;
    assign key_char_s = is_lower_s ? (char_in - 8'h20) : char_in;

    // Key decode and commit sequencing.
    always_comb begin
        next_state_s      = state_r;
        edit_buf_next_s   = edit_buf_r;
        edit_count_next_s = edit_count_r;
        dropped_next_s    = 1'b0;
        commit_s          = 1'b0;
        case (state_r)
            ST_EDIT: begin
                if (char_valid) begin
                    if (is_print_s) begin
                        if (edit_count_r == FULL) begin
                            dropped_next_s = 1'b1;
                        end else begin
                            edit_buf_next_s   = put_char(edit_buf_r, edit_count_r, key_char_s);
                            edit_count_next_s = edit_count_r + 6'd1;
                        end
                    end else if (char_in == 8'h08) begin
                        if (edit_count_r != 6'd0) begin
                            edit_buf_next_s   = put_char(edit_buf_r, edit_count_r - 6'd1, 8'h20);
                            edit_count_next_s = edit_count_r - 6'd1;
                        end else begin
                            edit_count_next_s = edit_count_r;
                        end
                    end else if (char_in == 8'h1B) begin
                        edit_buf_next_s   = BLANK;
                        edit_count_next_s = 6'd0;
                    end else if (char_in == 8'h0D) begin
                        if (edit_count_r != 6'd0) begin
                            next_state_s = ST_PENDING;
                        end else begin
                            dropped_next_s = 1'b1;
                        end
                    end else begin
                        dropped_next_s = 1'b1;
                    end
                end else begin
                    dropped_next_s = 1'b0;
                end
            end
            ST_PENDING: begin
                dropped_next_s = char_valid;
                if (frame_start) begin
                    commit_s     = 1'b1;
                    next_state_s = ST_COMMIT;
                end else begin
                    next_state_s = ST_PENDING;
                end
            end
            ST_COMMIT: begin
                dropped_next_s = char_valid;
                next_state_s   = ST_EDIT;
            end
            default: begin
                next_state_s = ST_EDIT;
            end
        endcase
    end

    // State, working buffer and committed bus registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_EDIT;
            edit_buf_r   <= BLANK;
            edit_count_r <= 6'd0;
            string_r     <= BLANK;
            numchar_r    <= 6'd0;
            ready_r      <= 1'b0;
            pending_r    <= 1'b0;
            dropped_r    <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            edit_buf_r   <= edit_buf_next_s;
            edit_count_r <= edit_count_next_s;
            ready_r      <= commit_s;
            pending_r    <= (next_state_s == ST_PENDING);
            dropped_r    <= dropped_next_s;
            if (commit_s) begin
                string_r  <= edit_buf_r;
                numchar_r <= edit_count_r;
            end else begin
                string_r  <= string_r;
                numchar_r <= numchar_r;
            end
        end
    end

    assign string_bus  = string_r;
    assign numchar     = numchar_r;
    assign ready       = ready_r;
    assign edit_string = edit_buf_r;
    assign edit_count  = edit_count_r;
    assign pending     = pending_r;
    assign dropped     = dropped_r;

endmodule
